// File: rtl/seg7_mux_n.sv
// seg7_mux_n : time-multiplexed 7-segment display driver for NUM_DIGITS digits.
//
// A slot timer steps a digit index once every REFRESH_CNT clocks. A new
// digit/dp pattern is captured on a load request and committed to the display
// shadow only at the frame boundary, so a frame is never drawn half-updated.
// Segment, dp and anode outputs are registered. A free-running 4-bit PWM
// counter gates the anode for brightness control.
//
// Ports
//   clk_100MHz  in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   digits      in   4*NUM_DIGITS, nibble k = digit k (digit 0 least significant)
//   dp_in       in   NUM_DIGITS, decimal point request per digit, active high
//   load        in   capture digits/dp_in into the pending buffer
//   busy        out  a captured load is waiting for the frame boundary
//   hex_mode    in   1 = glyphs 0-F, 0 = 0-9 only (A-F blank)
//   blank_lz    in   1 = suppress leading zeros (digit 0 never blanked)
//   brightness  in   4-bit PWM duty, 0 = 1/16 .. 15 = 16/16
//   blink_mask  in   NUM_DIGITS, digits that blink (only with SEG7_BLINK_EN)
//   seg         out  active-low segments, bit 6 = a .. bit 0 = g
//   dp          out  active-low decimal point
//   an          out  active-low anode enables, at most one low
//   frame_tick  out  one-clock pulse when the digit index wraps to 0
//
// Build option: define SEG7_BLINK_EN to add BLINK_FRAMES and blink_mask.
//
// Load handshake FSM
//   state   | meaning
//   ST_IDLE | no pending update, load accepted
//   ST_PEND | pending buffer full, waiting for index wrap (busy = 1)

module seg7_mux_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_CNT  = 100000
`ifdef SEG7_BLINK_EN
   ,parameter int BLINK_FRAMES = 125
`endif
) (
   input  logic                    clk_100MHz,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic                    busy,
   input  logic                    hex_mode,
   input  logic                    blank_lz,
   input  logic [3:0]              brightness,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int TW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_CNT - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {ST_IDLE, ST_PEND} state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_capture;
   logic   w_commit;

   logic [TW-1:0] r_timer;
   logic [IW-1:0] r_idx;
   logic [3:0]    r_pwm;

   logic [NUM_DIGITS-1:0][3:0] r_pend_dig;
   logic [NUM_DIGITS-1:0]      r_pend_dp;
   logic [NUM_DIGITS-1:0][3:0] r_shad_dig;
   logic [NUM_DIGITS-1:0]      r_shad_dp;

   logic [6:0]            r_seg;
   logic                  r_dp;
   logic [NUM_DIGITS-1:0] r_an;
   logic                  r_frame_tick;

   logic                  w_slot_end;
   logic                  w_wrap;
   logic [NUM_DIGITS-1:0] w_blank;
   logic                  w_allz;
   logic [3:0]            w_cur_dig;
   logic [6:0]            w_seg_nxt;
   logic                  w_dp_nxt;
   logic [NUM_DIGITS-1:0] w_an_sel;
   logic [NUM_DIGITS-1:0] w_an_nxt;
   logic                  w_lit;

   function automatic logic [6:0] f_decode(input logic [3:0] code, input logic hex);
      logic [6:0] g;
      case (code)
         4'h0:    g = 7'b0000001;
         4'h1:    g = 7'b1001111;
         4'h2:    g = 7'b0010010;
         4'h3:    g = 7'b0000110;
         4'h4:    g = 7'b1001100;
         4'h5:    g = 7'b0100100;
         4'h6:    g = 7'b0100000;
         4'h7:    g = 7'b0001111;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0000100;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b1100000;
         4'hC:    g = 7'b0110001;
         4'hD:    g = 7'b1000010;
         4'hE:    g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      if (!hex && code > 4'h9) begin
         g = 7'b1111111;
      end
      return g;
   endfunction

   assign w_slot_end = (r_timer == TIMER_LAST);
   assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);

   // Slot timer, digit index and PWM counter
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
         r_idx   <= '0;
         r_pwm   <= '0;
      end else begin
         r_pwm <= r_pwm + 4'd1;
         if (w_slot_end) begin
            r_timer <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         end else begin
            r_timer <= r_timer + 1'b1;
         end
      end
   end

   // Load handshake
   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Commit depends on the registered state, so a load accepted on a wrap
   // clock waits for the following wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_PEND;
            end
         end
         ST_PEND: begin
            if (w_wrap) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (r_state == ST_PEND);

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_pend_dig <= '0;
         r_pend_dp  <= '0;
         r_shad_dig <= '0;
         r_shad_dp  <= '0;
      end else begin
         if (w_capture) begin
            r_pend_dig <= digits;
            r_pend_dp  <= dp_in;
         end
         if (w_commit) begin
            r_shad_dig <= r_pend_dig;
            r_shad_dp  <= r_pend_dp;
         end
      end
   end

   // w_blank[k] is set when digit k and every digit above it are zero
   always_comb begin
      w_blank = '0;
      w_allz  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         w_allz     = w_allz & (r_shad_dig[k] == 4'h0);
         w_blank[k] = w_allz;
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] r_blink_cnt;
   logic          r_blink_on;

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if (w_wrap) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end
      end
   end

   assign w_lit = (r_pwm <= brightness) && (r_blink_on || !blink_mask[r_idx]);
`else
   assign w_lit = (r_pwm <= brightness);
`endif

   assign w_cur_dig = r_shad_dig[r_idx];
   assign w_seg_nxt = (blank_lz && w_blank[r_idx]) ? 7'b1111111 : f_decode(w_cur_dig, hex_mode);
   assign w_dp_nxt  = ~r_shad_dp[r_idx];
   assign w_an_sel  = ~(NUM_DIGITS'(1) << r_idx);
   assign w_an_nxt  = w_lit ? w_an_sel : '1;

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         r_seg        <= 7'b1111111;
         r_dp         <= 1'b1;
         r_an         <= '1;
         r_frame_tick <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_dp         <= w_dp_nxt;
         r_an         <= w_an_nxt;
         r_frame_tick <= w_wrap;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign an         = r_an;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_mux_n.sv
module tb_seg7_mux_n;

   localparam int ND = 4;

   localparam logic [6:0] G0 = 7'b0000001;
   localparam logic [6:0] G1 = 7'b1001111;
   localparam logic [6:0] G2 = 7'b0010010;
   localparam logic [6:0] G3 = 7'b0000110;
   localparam logic [6:0] G4 = 7'b1001100;
   localparam logic [6:0] G5 = 7'b0100100;
   localparam logic [6:0] G7 = 7'b0001111;
   localparam logic [6:0] GX = 7'b1111111;

   logic        clk_100MHz = 1'b0;
   logic        rst        = 1'b1;
   logic [15:0] digits     = '0;
   logic [3:0]  dp_in      = '0;
   logic        load       = 1'b0;
   logic        hex_mode   = 1'b0;
   logic        blank_lz   = 1'b0;
   logic [3:0]  brightness = 4'hF;
   logic        busy;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;
`ifdef SEG7_BLINK_EN
   logic [3:0]  blink_mask = '0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   seg7_mux_n #(
      .NUM_DIGITS  (ND),
      .REFRESH_CNT (4)
`ifdef SEG7_BLINK_EN
      ,.BLINK_FRAMES(2)
`endif
   ) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .digits     (digits),
      .dp_in      (dp_in),
      .load       (load),
      .busy       (busy),
      .hex_mode   (hex_mode),
      .blank_lz   (blank_lz),
      .brightness (brightness),
`ifdef SEG7_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_tick (frame_tick)
   );

   typedef struct {
      logic       hex;
      logic [3:0] code;
      logic [6:0] exp_seg;
   } dec_vec_t;

   dec_vec_t vt[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_100MHz);
   endtask

   task automatic wait_an(input logic [3:0] e, input string nm);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         if (an === e) found = 1'b1;
         else tick();
      end
      chk({nm, " wait an"}, 32'(found), 32'd1);
   endtask

   // Loads a pattern, waits for the wrap commit, returns at the first sample
   // of the new frame (an = 1110).
   task automatic load_and_apply(input logic [15:0] d, input logic [3:0] dv, input string nm);
      bit found;
      digits = d;
      dp_in  = dv;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      chk({nm, " busy set"}, 32'(busy), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         if (busy === 1'b0) found = 1'b1;
         else tick();
      end
      chk({nm, " busy clear"}, 32'(found), 32'd1);
      wait_an(4'b1110, nm);
   endtask

   // Checks one whole frame starting at its first sample; ends on the first
   // sample of the next frame.
   task automatic sweep(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic [3:0] dv, input string nm);
      logic [6:0] es [4];
      logic [3:0] ea;
      bit         edp;
      int         k;
      es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
      for (int j = 0; j < 16; j++) begin
         k      = j / 4;
         ea     = 4'b1111;
         ea[k]  = 1'b0;
         edp    = ~dv[k];
         chk($sformatf("%s an j=%0d", nm, j), 32'(an), 32'(ea));
         if (j % 4 == 1) begin
            chk($sformatf("%s seg d%0d", nm, k), 32'(seg), 32'(es[k]));
            chk($sformatf("%s dp d%0d", nm, k), 32'(dp), 32'(edp));
         end
         chk($sformatf("%s frame_tick j=%0d", nm, j), 32'(frame_tick), 32'(j == 15));
         tick();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      bit seen;
      int cnt;
      bit one_hot_ok;

      vt[0]  = '{1'b0, 4'h0, 7'b0000001};
      vt[1]  = '{1'b0, 4'h7, 7'b0001111};
      vt[2]  = '{1'b0, 4'h9, 7'b0000100};
      vt[3]  = '{1'b0, 4'hB, 7'b1111111};
      vt[4]  = '{1'b1, 4'hB, 7'b1100000};
      vt[5]  = '{1'b0, 4'hF, 7'b1111111};
      vt[6]  = '{1'b1, 4'hA, 7'b0001000};
      vt[7]  = '{1'b1, 4'hC, 7'b0110001};
      vt[8]  = '{1'b1, 4'hD, 7'b1000010};
      vt[9]  = '{1'b1, 4'hE, 7'b0110000};
      vt[10] = '{1'b1, 4'hF, 7'b0111000};
      vt[11] = '{1'b1, 4'h8, 7'b0000000};

      // reset state
      tick();
      chk("rst an", 32'(an), 32'hF);
      chk("rst seg", 32'(seg), 32'(GX));
      chk("rst dp", 32'(dp), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst frame_tick", 32'(frame_tick), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      sweep(G0, G0, G0, G0, 4'b0000, "post-reset");

      // basic scan
      load_and_apply(16'h1234, 4'b0010, "load1234");
      sweep(G4, G3, G2, G1, 4'b0010, "scan1234");

      // mid-frame load, second load ignored, no partial update
      tick(); tick(); tick(); tick(); tick();
      digits = 16'h0005; dp_in = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      chk("midload busy", 32'(busy), 32'd1);
      digits = 16'h0009; load = 1'b1;
      tick();
      load = 1'b0;
      chk("busy load ignored busy", 32'(busy), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (frame_tick === 1'b1) begin
            seen = 1'b1;
            chk("wrap busy clear", 32'(busy), 32'd0);
            chk("wrap seg old d3", 32'(seg), 32'(G1));
         end else begin
            chk("pend busy", 32'(busy), 32'd1);
            case (an)
               4'b1101: chk("pend seg d1", 32'(seg), 32'(G3));
               4'b1011: chk("pend seg d2", 32'(seg), 32'(G2));
               4'b0111: chk("pend seg d3", 32'(seg), 32'(G1));
               default: chk("pend an", 32'(an), 32'b1101);
            endcase
            tick();
         end
      end
      chk("pend frame_tick seen", 32'(seen), 32'd1);
      tick();
      sweep(G5, G0, G0, G0, 4'b0000, "scan0005");
      chk("after commit busy", 32'(busy), 32'd0);

      // leading-zero blanking
      blank_lz = 1'b1;
      load_and_apply(16'h0070, 4'b0100, "load0070");
      sweep(G0, G7, GX, GX, 4'b0100, "blank0070");
      load_and_apply(16'h0000, 4'b0000, "load0000");
      sweep(G0, GX, GX, GX, 4'b0000, "blank0000");
      load_and_apply(16'h1000, 4'b0000, "load1000");
      sweep(G0, G0, G0, G1, 4'b0000, "blank1000");
      blank_lz = 1'b0;

      // decoder table
      for (int v = 0; v < 12; v++) begin
         hex_mode = vt[v].hex;
         load_and_apply({12'h000, vt[v].code}, 4'b0000, $sformatf("dec%0d", v));
         chk($sformatf("dec%0d hex=%0d code=%0h seg", v, vt[v].hex, vt[v].code),
             32'(seg), 32'(vt[v].exp_seg));
      end
      hex_mode = 1'b0;

      // brightness PWM
      brightness = 4'd3;
      tick();
      cnt = 0; one_hot_ok = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (an != 4'b1111) cnt++;
         if ($countones(~an) > 1) one_hot_ok = 1'b0;
         tick();
      end
      chk("bright3 lit count", 32'(cnt), 32'd4);
      chk("bright3 one-hot", 32'(one_hot_ok), 32'd1);
      brightness = 4'd0;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (an != 4'b1111) cnt++;
         tick();
      end
      chk("bright0 lit count", 32'(cnt), 32'd1);
      brightness = 4'd15;
      tick();
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (an != 4'b1111) cnt++;
         tick();
      end
      chk("bright15 lit count", 32'(cnt), 32'd16);

      // reset mid-slot discards the pending load
      digits = 16'h0008; dp_in = 4'b1111; load = 1'b1;
      tick();
      load = 1'b0;
      chk("prereset busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst an", 32'(an), 32'hF);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst seg", 32'(seg), 32'(GX));
      chk("async rst dp", 32'(dp), 32'd1);
      tick();
      tick();
      rst = 1'b0;
      tick();
      sweep(G0, G0, G0, G0, 4'b0000, "after-rst");
      chk("after-rst busy", 32'(busy), 32'd0);

`ifdef SEG7_BLINK_EN
      rst = 1'b1;
      tick();
      blink_mask = 4'b0001;
      rst = 1'b0;
      for (int s = 0; s < 80; s++) begin
         tick();
         if (s % 16 == 1)
            chk($sformatf("blink d0 frame %0d", s / 16), 32'(an),
                ((s / 16 == 2) || (s / 16 == 3)) ? 32'hF : 32'hE);
         if (s % 16 == 5)
            chk($sformatf("blink d1 frame %0d", s / 16), 32'(an), 32'hD);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
